mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit; the initiator that drives the word-wide data memory (DataMem).
//  Decodes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW from EX/MEM, translates byte addresses to word indices,
//  and sign-/zero-extends load data. Builds sub-word stores with a 2-cycle read-modify-write,
//  because DataMem only supports full-word writes. Detects misaligned or illegal accesses.
// PARAMETERS
//  ADDR_W  6  width of the DataMem word index; 64 words = 256 bytes
// PORTS
//  clk             in   1       system clock; all state updates on posedge
//  rst             in   1       synchronous, active-high reset
//  lsu_valid       in   1       request present from EX/MEM
//  lsu_is_load     in   1       request is a load
//  lsu_is_store    in   1       request is a store
//  lsu_funct3      in   3       0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (loads); 0 SB, 1 SH, 2 SW (stores)
//  lsu_addr        in   32      byte address (rs1 + imm)
//  lsu_store_data  in   32      rs2 value
//  lsu_stall       out  1       hold the MEM stage (and upstream) this cycle
//  lsu_done        out  1       one-cycle pulse: operation complete (registered)
//  lsu_load_data   out  32      extended load result; valid while lsu_done=1
//  lsu_fault       out  1       pulse with lsu_done: misaligned or illegal access
//  dm_addr         out  ADDR_W  word index to DataMem = lsu_addr[ADDR_W+1:2]
//  dm_wdata        out  32      write word to DataMem
//  dm_we           out  1       DataMem write enable
//  dm_rdata        in   32      DataMem read data (combinational, same cycle as dm_addr)
// BEHAVIOUR
//  States: IDLE, ST_WR. Request is accepted only in IDLE with lsu_valid=1.
//  Load (accepted at T): dm_addr driven at T; byte/half lane selected by lsu_addr[1:0]; result
//   extended (LB/LH sign, LBU/LHU zero) and registered; lsu_done=1 and lsu_load_data at T+1.
//  SW (T): dm_we=1, dm_wdata=lsu_store_data at T; lsu_done at T+1. lsu_stall stays 0.
//  SB/SH (T): read word at T, merge store bytes into lane(s), latch into wbuf, go to ST_WR;
//   lsu_stall=1 only at T. At T+1 (ST_WR): dm_we=1, dm_wdata=wbuf, same dm_addr (latched);
//   lsu_valid ignored (held request); return to IDLE. lsu_done at T+2.
//  Misaligned: LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]=1. Illegal: funct3 in {3,6,7} (loads),
//   funct3>2 (stores), or is_load&is_store. Both cases: dm_we=0, no stall, lsu_done=1,
//   lsu_fault=1, lsu_load_data=0 at T+1.
//  lsu_valid=1 with is_load=is_store=0: no-op, no done pulse.
//  dm_we is 0 in all cases not listed above. Address bits above ADDR_W+1 are ignored
//   (addresses wrap modulo memory size).
//  lsu_load_data holds its last value when lsu_done=0.
//  Reset: state=IDLE, lsu_done=0, lsu_fault=0, lsu_load_data=0, wbuf=0; dm_we=0 and
//   lsu_stall=0 during reset. Reset in ST_WR abandons the write; memory is left unchanged.
// STRUCTURE
//  lsu_pkg: funct3 encodings (F3_B/H/W/BU/HU), state encoding, MEM_BYTES/ADDR_W defaults.
//  Sub-module lsu_lane_unit (combinational): load extract/extend and store byte-merge,
//   driven by funct3 and addr[1:0]. Top level holds the FSM, wbuf, latched dm_addr and
//   output registers.
// TESTING
//  1 Preload word 3 = 0x8000_80F0; LB @0x0C -> done at T+1, data 0xFFFF_FFF0; LBU -> 0x0000_00F0.
//  2 LH @0x0E on same word -> 0xFFFF_8000; LHU @0x0E -> 0x0000_8000; LW @0x0C -> 0x8000_80F0.
//  3 Word 5 = 0x1122_3344; SB 0xAB @0x15 -> stall at T only, dm_we at T+1, word 5 = 0x1122_AB44,
//    done at T+2; next request accepted at T+2.
//  4 SW 0xDEAD_BEEF @0x10 -> dm_we at T, word 4 = 0xDEAD_BEEF, done at T+1, no stall.
//  5 LW @0x0D, SH @0x13, LB funct3=3 -> fault+done at T+1, dm_we never 1, memory unchanged.
//  6 rst=1 in ST_WR of an SH -> no write, next cycle IDLE, all outputs 0; addr 0x104 hits word 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 codes, FSM states,
// memory geometry and the access legality check used by the top level.
package lsu_pkg;

    localparam int MEM_BYTES  = 256;
    localparam int LSU_ADDR_W = 6;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WR   = 1'b1;

    // True when the request must complete as a fault: bad encoding or misaligned address.
    function automatic logic access_fault(input logic is_load, input logic is_store,
                                          input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal = (is_load && is_store)
               || (is_load && (funct3 == 3'd3 || funct3[2:1] == 2'b11))
               || (is_store && funct3 > F3_W);
        misaligned = (funct3 == F3_W && addr_lo != 2'b00)
                  || ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte-lane datapath: extracts and extends load data, and merges sub-word store
// data into the word just read from memory.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [15:0] store_data,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [3:0]  byte_en;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_ext = {24'h0, shifted[7:0]};
            F3_HU:   load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        byte_en = 4'b0000;
        if (funct3 == F3_B) begin
            byte_en = 4'b0001 << addr_lo;
        end else if (funct3 == F3_H) begin
            byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
    end

    // SB replicates the low byte into every lane; SH places its two bytes by lane parity.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_src;
            assign lane_src = (funct3 == F3_B) ? store_data[7:0] : store_data[(gi % 2) * 8 +: 8];
            assign merged[gi * 8 +: 8] = byte_en[gi] ? lane_src : rdata[gi * 8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit driving a word-wide data memory; sub-word stores
// are done as a read in IDLE followed by a full-word write in ST_WR.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    input  logic              lsu_is_load,
    input  logic              lsu_is_store,
    input  logic [2:0]        lsu_funct3,
    input  logic [31:0]       lsu_addr,
    input  logic [31:0]       lsu_store_data,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [31:0]       lsu_load_data,
    output logic              lsu_fault,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    input  logic [31:0]       dm_rdata
);

    logic [0:0]        state_reg, state_next;
    logic [31:0]       wbuf_reg, wbuf_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              done_reg, done_next;
    logic              fault_reg, fault_next;
    logic [31:0]       load_data_reg, load_data_next;

    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       load_ext;
    logic [31:0]       merged;
    logic              accept;
    logic              req_fault;
    logic              unused_addr_hi;

    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign req_addr       = lsu_addr[ADDR_W+1:2];
    assign unused_addr_hi = ^lsu_addr[31:ADDR_W+2];
    assign accept         = lsu_valid && (lsu_is_load || lsu_is_store);
    assign req_fault      = access_fault(lsu_is_load, lsu_is_store, lsu_funct3, lsu_addr[1:0]);

    lsu_lane_unit u_lane (
        .funct3     (lsu_funct3),
        .addr_lo    (lsu_addr[1:0]),
        .rdata      (dm_rdata),
        .store_data (lsu_store_data[15:0]),
        .load_ext   (load_ext),
        .merged     (merged)
    );

    always_comb begin
        state_next     = state_reg;
        wbuf_next      = wbuf_reg;
        addr_next      = addr_reg;
        done_next      = 1'b0;
        fault_next     = 1'b0;
        load_data_next = load_data_reg;
        dm_addr        = req_addr;
        dm_wdata       = lsu_store_data;
        dm_we          = 1'b0;
        lsu_stall      = 1'b0;

        if (state_reg == ST_WR) begin
            dm_addr    = addr_reg;
            dm_wdata   = wbuf_reg;
            dm_we      = 1'b1;
            done_next  = 1'b1;
            state_next = ST_IDLE;
        end else if (accept) begin
            done_next = 1'b1;
            if (req_fault) begin
                fault_next     = 1'b1;
                load_data_next = 32'h0;
            end else if (lsu_is_load) begin
                load_data_next = load_ext;
            end else if (lsu_funct3 == F3_W) begin
                dm_we = 1'b1;
            end else begin
                lsu_stall  = 1'b1;
                wbuf_next  = merged;
                addr_next  = req_addr;
                state_next = ST_WR;
                done_next  = 1'b0;
            end
        end

        // A reset landing in ST_WR must not let the pending write escape.
        if (rst) begin
            dm_we     = 1'b0;
            lsu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wbuf_reg      <= 32'h0;
            addr_reg      <= '0;
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            load_data_reg <= 32'h0;
        end else begin
            state_reg     <= state_next;
            wbuf_reg      <= wbuf_next;
            addr_reg      <= addr_next;
            done_reg      <= done_next;
            fault_reg     <= fault_next;
            load_data_reg <= load_data_next;
        end
    end

    assign lsu_done      = done_reg;
    assign lsu_fault     = fault_reg;
    assign lsu_load_data = load_data_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus random traffic checked against
// a byte-addressed reference memory.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid = 1'b0;
    logic        lsu_is_load = 1'b0;
    logic        lsu_is_store = 1'b0;
    logic [2:0]  lsu_funct3 = 3'd0;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_store_data = 32'h0;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_load_data;
    logic        lsu_fault;
    logic [5:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [31:0] dm_rdata;

    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'h0;
    logic [7:0]  ref_mem [256];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid      (lsu_valid),
        .lsu_is_load    (lsu_is_load),
        .lsu_is_store   (lsu_is_store),
        .lsu_funct3     (lsu_funct3),
        .lsu_addr       (lsu_addr),
        .lsu_store_data (lsu_store_data),
        .lsu_stall      (lsu_stall),
        .lsu_done       (lsu_done),
        .lsu_load_data  (lsu_load_data),
        .lsu_fault      (lsu_fault),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_we          (dm_we),
        .dm_rdata       (dm_rdata)
    );

    assign dm_rdata = mem[dm_addr];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (dm_we) mem[dm_addr] <= dm_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1;
        pre_idx = 6'(idx);
        pre_val = val;
        @(negedge clk);
        pre_we = 1'b0;
        for (int b = 0; b < 4; b++) ref_mem[idx * 4 + b] = val[b * 8 +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[idx * 4 + 3], ref_mem[idx * 4 + 2], ref_mem[idx * 4 + 1], ref_mem[idx * 4]};
    endfunction

    function automatic logic exp_fault(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [31:0] addr);
        if (ld && st) return 1'b1;
        if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (st && f3 > 2) return 1'b1;
        if (f3 == 2 && addr % 4 != 0) return 1'b1;
        if ((f3 == 1 || f3 == 5) && addr % 2 != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int a;
        int val;
        a = addr % 256;
        case (f3)
            0: begin val = ref_mem[a]; if (val >= 128) val -= 256; end
            4: val = ref_mem[a];
            1: begin val = ref_mem[a] + 256 * ref_mem[a + 1]; if (val >= 32768) val -= 65536; end
            5: val = ref_mem[a] + 256 * ref_mem[a + 1];
            default: return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
        endcase
        return 32'(val);
    endfunction

    task automatic do_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        logic act, flt, sw, rmw;
        logic [31:0] exp_ld;
        int a;
        act = ld || st;
        flt = act && exp_fault(ld, st, f3, addr);
        sw  = act && !flt && st && f3 == 2;
        rmw = act && !flt && st && f3 < 2;
        exp_ld = (act && !flt && ld) ? ref_load(f3, addr) : 32'h0;
        a = addr % 256;

        @(negedge clk);
        check({tag, " done_idle"}, lsu_done, 0);
        lsu_valid = 1'b1;
        lsu_is_load = ld;
        lsu_is_store = st;
        lsu_funct3 = f3;
        lsu_addr = addr;
        lsu_store_data = data;
        #1;
        check({tag, " stall_T"}, lsu_stall, rmw);
        check({tag, " we_T"}, dm_we, sw);
        if (act && !flt) check({tag, " addr_T"}, dm_addr, addr[7:2]);
        if (sw) check({tag, " wdata_T"}, dm_wdata, data);

        @(negedge clk);
        if (rmw) begin
            #1;
            check({tag, " done_T1"}, lsu_done, 0);
            check({tag, " we_T1"}, dm_we, 1);
            check({tag, " stall_T1"}, lsu_stall, 0);
            check({tag, " addr_T1"}, dm_addr, addr[7:2]);
            @(negedge clk);
        end
        lsu_valid = 1'b0;
        #1;
        check({tag, " done"}, lsu_done, act);
        if (act) check({tag, " fault"}, lsu_fault, flt);
        if (act && (ld || flt)) check({tag, " data"}, lsu_load_data, exp_ld);

        if (sw) for (int b = 0; b < 4; b++) ref_mem[a + b] = data[b * 8 +: 8];
        if (rmw && f3 == 0) ref_mem[a] = data[7:0];
        if (rmw && f3 == 1) begin
            ref_mem[a] = data[7:0];
            ref_mem[a + 1] = data[15:8];
        end
        $display("op %s ld=%0b st=%0b f3=%0d addr=%h data=%h -> done=%0b fault=%0b load=%h",
                 tag, ld, st, f3, addr, data, lsu_done, lsu_fault, lsu_load_data);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 64; i++) check($sformatf("%s word%0d", tag, i), mem[i], ref_word(i));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) preload(i, 32'h0);
        @(negedge clk);
        lsu_valid = 1'b1;
        lsu_is_store = 1'b1;
        lsu_funct3 = 3'd2;
        #1;
        check("reset we", dm_we, 0);
        check("reset stall", lsu_stall, 0);
        check("reset done", lsu_done, 0);
        check("reset fault", lsu_fault, 0);
        check("reset data", lsu_load_data, 0);
        @(negedge clk);
        lsu_valid = 1'b0;
        lsu_is_store = 1'b0;
        rst = 1'b0;

        preload(3, 32'h8000_80F0);
        do_op("LB0C", 1, 0, 0, 32'h0C, 0);
        check("LB0C val", lsu_load_data, 32'hFFFF_FFF0);
        do_op("LBU0C", 1, 0, 4, 32'h0C, 0);
        check("LBU0C val", lsu_load_data, 32'h0000_00F0);
        do_op("LH0E", 1, 0, 1, 32'h0E, 0);
        check("LH0E val", lsu_load_data, 32'hFFFF_8000);
        do_op("LHU0E", 1, 0, 5, 32'h0E, 0);
        check("LHU0E val", lsu_load_data, 32'h0000_8000);
        do_op("LW0C", 1, 0, 2, 32'h0C, 0);
        check("LW0C val", lsu_load_data, 32'h8000_80F0);

        preload(5, 32'h1122_3344);
        do_op("SB15", 0, 1, 0, 32'h15, 32'h0000_00AB);
        check("SB15 word5", mem[5], 32'h1122_AB44);
        do_op("SW10", 0, 1, 2, 32'h10, 32'hDEAD_BEEF);
        check("SW10 word4", mem[4], 32'hDEAD_BEEF);

        do_op("LW0D", 1, 0, 2, 32'h0D, 0);
        do_op("SH13", 0, 1, 1, 32'h13, 32'h0000_1234);
        do_op("LBf3", 1, 0, 3, 32'h0C, 0);
        do_op("NOP", 0, 0, 2, 32'h10, 0);
        check_mem("after faults");

        preload(2, 32'h5566_7788);
        @(negedge clk);
        lsu_valid = 1'b1;
        lsu_is_store = 1'b1;
        lsu_funct3 = 3'd1;
        lsu_addr = 32'h08;
        lsu_store_data = 32'h0000_BEEF;
        #1;
        check("rstWR stall_T", lsu_stall, 1);
        @(negedge clk);
        lsu_valid = 1'b0;
        lsu_is_store = 1'b0;
        rst = 1'b1;
        #1;
        check("rstWR we", dm_we, 0);
        check("rstWR stall", lsu_stall, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstWR done", lsu_done, 0);
        check("rstWR fault", lsu_fault, 0);
        check("rstWR data", lsu_load_data, 0);
        check("rstWR word2", mem[2], 32'h5566_7788);
        @(negedge clk);
        #1;
        check("rstWR idle we", dm_we, 0);
        preload(1, 32'hCAFE_F00D);
        do_op("LW104", 1, 0, 2, 32'h104, 0);
        check("LW104 val", lsu_load_data, 32'hCAFE_F00D);

        for (int n = 0; n < 200; n++) begin
            int kind;
            logic ld, st;
            logic [2:0] f3;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            ld = kind < 5 || (kind == 9 && $urandom_range(0, 1) == 1);
            st = (kind >= 5 && kind <= 8) || (kind == 9 && $urandom_range(0, 1) == 1);
            f3 = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
            do_op($sformatf("rnd%0d", n), ld, st, f3, addr, $urandom);
        end
        check_mem("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
